// File: rtl/ppu_sprite_line_engine_if.sv
// Sprite line engine bus: line control, OAM and pattern fetch ports, pixel query and sprite pixel result.
// The engine attaches through the slave modport; the driving environment uses master.
interface ppu_sprite_line_engine_if #(
  parameter int NUM_SPRITES = 64,
  parameter int TILE_SIZE   = 16,
  parameter int PAT_ADDR_W  = 12
);
  localparam int OAM_W = $clog2(NUM_SPRITES);

  logic                  line_start;
  logic [7:0]            eval_line;
  logic [OAM_W-1:0]      oam_addr;
  logic [31:0]           oam_data;
  logic [PAT_ADDR_W-1:0] pat_addr;
  logic [TILE_SIZE-1:0]  pat_plane0;
  logic [TILE_SIZE-1:0]  pat_plane1;
  logic                  pix_valid;
  logic [8:0]            pix_x;
  logic [4:0]            spr_pal_index;
  logic                  spr_opaque;
  logic                  spr_behind;
  logic                  spr_zero;
  logic                  overflow;
  logic                  ready;

  modport master (
    output line_start, eval_line, oam_data, pat_plane0, pat_plane1, pix_valid, pix_x,
    input  oam_addr, pat_addr, spr_pal_index, spr_opaque, spr_behind, spr_zero, overflow, ready
  );

  modport slave (
    input  line_start, eval_line, oam_data, pat_plane0, pat_plane1, pix_valid, pix_x,
    output oam_addr, pat_addr, spr_pal_index, spr_opaque, spr_behind, spr_zero, overflow, ready
  );
endinterface

// File: rtl/ppu_sprite_line_engine.sv
// Per-scanline sprite engine: scans OAM for sprites on the line, fetches their pattern rows,
// then resolves the sprite pixel for each queried column with lowest-slot-wins priority.
module ppu_sprite_line_engine #(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int TILE_SIZE    = 16,
  parameter int PAT_ADDR_W   = 12
) (
  input logic clk,
  input logic reset,
  ppu_sprite_line_engine_if.slave bus
);
  localparam int OAM_W   = $clog2(NUM_SPRITES);
  localparam int EVAL_W  = OAM_W + 1;
  localparam int ROW_W   = $clog2(TILE_SIZE);
  localparam int SLOT_IW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int SLOT_CW = $clog2(MAX_PER_LINE + 1);
  localparam logic [EVAL_W-1:0]  EVAL_LAST = EVAL_W'(NUM_SPRITES);
  localparam logic [EVAL_W-1:0]  ADDR_LAST = EVAL_W'(NUM_SPRITES - 1);
  localparam logic [SLOT_CW-1:0] SLOT_FULL = SLOT_CW'(MAX_PER_LINE);
  localparam logic [8:0]         TILE_9    = 9'(TILE_SIZE);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, FETCH = 2'd2, READY = 2'd3} state_t;

  function automatic logic [TILE_SIZE-1:0] bit_rev(input logic [TILE_SIZE-1:0] v);
    for (int i = 0; i < TILE_SIZE; i++) bit_rev[i] = v[TILE_SIZE-1-i];
  endfunction

  function automatic logic [PAT_ADDR_W-1:0] row_addr(input logic [7:0] tile, input logic [ROW_W-1:0] row);
    row_addr = PAT_ADDR_W'(tile) * PAT_ADDR_W'(TILE_SIZE) + PAT_ADDR_W'(row);
  endfunction

  state_t                state_r;
  logic [EVAL_W-1:0]     eval_cnt_r;
  logic [7:0]            line_r;
  logic [OAM_W-1:0]      oam_addr_r;
  logic [PAT_ADDR_W-1:0] pat_addr_r;
  logic [SLOT_CW-1:0]    slot_cnt_r;
  logic [SLOT_IW-1:0]    fetch_idx_r;
  logic                  fetch_cap_r;
  logic                  overflow_r;
  logic                  ready_r;
  // Slot attribute is packed as {hflip, behind, palette[2:0]}.
  logic [7:0]            slot_x_r    [MAX_PER_LINE];
  logic [7:0]            slot_tile_r [MAX_PER_LINE];
  logic [ROW_W-1:0]      slot_row_r  [MAX_PER_LINE];
  logic [4:0]            slot_attr_r [MAX_PER_LINE];
  logic                  slot_zero_r [MAX_PER_LINE];
  logic [TILE_SIZE-1:0]  slot_p0_r   [MAX_PER_LINE];
  logic [TILE_SIZE-1:0]  slot_p1_r   [MAX_PER_LINE];
  logic [4:0]            pal_r;
  logic                  opaque_r, behind_r, zero_r;

  logic [7:0]            oam_x_s, oam_y_s, oam_tile_s, oam_attr_s;
  logic                  attr_unused_s;
  logic [8:0]            d_s;
  logic                  y_hit_s, accept_s, ovf_hit_s;
  logic [ROW_W-1:0]      row_s;
  logic [SLOT_IW-1:0]    slot_wr_s, fetch_nx_s;
  logic [SLOT_CW-1:0]    slot_cnt_nx_s;
  logic [PAT_ADDR_W-1:0] first_addr_s, next_addr_s;

  // OAM entry decode and Y test; d is 9-bit so sprites above the line never wrap into a hit.
  always_comb begin
    oam_x_s       = bus.oam_data[7:0];
    oam_y_s       = bus.oam_data[15:8];
    oam_tile_s    = bus.oam_data[23:16];
    oam_attr_s    = bus.oam_data[31:24];
    attr_unused_s = ^oam_attr_s[4:3];
    d_s           = {1'b0, line_r} - {1'b0, oam_y_s};
    y_hit_s       = (d_s < TILE_9);
    if (oam_attr_s[7]) begin
      row_s = ~d_s[ROW_W-1:0];
    end else begin
      row_s = d_s[ROW_W-1:0];
    end
    accept_s  = (state_r == EVAL) && (eval_cnt_r != {EVAL_W{1'b0}}) && y_hit_s && (slot_cnt_r != SLOT_FULL);
    ovf_hit_s = (state_r == EVAL) && (eval_cnt_r != {EVAL_W{1'b0}}) && y_hit_s && (slot_cnt_r == SLOT_FULL);
    slot_wr_s = slot_cnt_r[SLOT_IW-1:0];
    if (accept_s) begin
      slot_cnt_nx_s = slot_cnt_r + SLOT_CW'(1'b1);
    end else begin
      slot_cnt_nx_s = slot_cnt_r;
    end
  end

  // Pattern addresses for the first slot (possibly written this very cycle) and the next slot.
  always_comb begin
    if (slot_cnt_r == {SLOT_CW{1'b0}}) begin
      first_addr_s = row_addr(oam_tile_s, row_s);
    end else begin
      first_addr_s = row_addr(slot_tile_r[0], slot_row_r[0]);
    end
    fetch_nx_s  = fetch_idx_r + SLOT_IW'(1'b1);
    next_addr_s = row_addr(slot_tile_r[fetch_nx_s], slot_row_r[fetch_nx_s]);
  end

  // Line state machine: OAM scan, pattern fetch and line-buffer hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      eval_cnt_r  <= {EVAL_W{1'b0}};
      line_r      <= 8'h00;
      oam_addr_r  <= {OAM_W{1'b0}};
      pat_addr_r  <= {PAT_ADDR_W{1'b0}};
      slot_cnt_r  <= {SLOT_CW{1'b0}};
      fetch_idx_r <= {SLOT_IW{1'b0}};
      fetch_cap_r <= 1'b0;
      overflow_r  <= 1'b0;
      ready_r     <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        slot_p0_r[i] <= {TILE_SIZE{1'b0}};
        slot_p1_r[i] <= {TILE_SIZE{1'b0}};
      end
    end else if (bus.line_start) begin
      state_r     <= EVAL;
      eval_cnt_r  <= {EVAL_W{1'b0}};
      line_r      <= bus.eval_line;
      oam_addr_r  <= {OAM_W{1'b0}};
      pat_addr_r  <= {PAT_ADDR_W{1'b0}};
      slot_cnt_r  <= {SLOT_CW{1'b0}};
      fetch_idx_r <= {SLOT_IW{1'b0}};
      fetch_cap_r <= 1'b0;
      overflow_r  <= 1'b0;
      ready_r     <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        slot_p0_r[i] <= {TILE_SIZE{1'b0}};
        slot_p1_r[i] <= {TILE_SIZE{1'b0}};
      end
    end else begin
      case (state_r)
        EVAL: begin
          if (accept_s) begin
            slot_x_r[slot_wr_s]    <= oam_x_s;
            slot_tile_r[slot_wr_s] <= oam_tile_s;
            slot_row_r[slot_wr_s]  <= row_s;
            slot_attr_r[slot_wr_s] <= {oam_attr_s[6], oam_attr_s[5], oam_attr_s[2:0]};
            slot_zero_r[slot_wr_s] <= (eval_cnt_r == EVAL_W'(1'b1));
            slot_cnt_r             <= slot_cnt_nx_s;
          end
          if (ovf_hit_s) overflow_r <= 1'b1;
          if (eval_cnt_r < ADDR_LAST) oam_addr_r <= oam_addr_r + OAM_W'(1'b1);
          if (eval_cnt_r == EVAL_LAST) begin
            if (slot_cnt_nx_s == {SLOT_CW{1'b0}}) begin
              state_r <= READY;
              ready_r <= 1'b1;
            end else begin
              state_r     <= FETCH;
              fetch_idx_r <= {SLOT_IW{1'b0}};
              fetch_cap_r <= 1'b0;
              pat_addr_r  <= first_addr_s;
            end
          end else begin
            eval_cnt_r <= eval_cnt_r + EVAL_W'(1'b1);
          end
        end
        FETCH: begin
          if (!fetch_cap_r) begin
            fetch_cap_r <= 1'b1;
          end else begin
            fetch_cap_r <= 1'b0;
            if (slot_attr_r[fetch_idx_r][4]) begin
              slot_p0_r[fetch_idx_r] <= bit_rev(bus.pat_plane0);
              slot_p1_r[fetch_idx_r] <= bit_rev(bus.pat_plane1);
            end else begin
              slot_p0_r[fetch_idx_r] <= bus.pat_plane0;
              slot_p1_r[fetch_idx_r] <= bus.pat_plane1;
            end
            if ((SLOT_CW'(fetch_idx_r) + SLOT_CW'(1'b1)) == slot_cnt_r) begin
              state_r <= READY;
              ready_r <= 1'b1;
            end else begin
              fetch_idx_r <= fetch_nx_s;
              pat_addr_r  <= next_addr_s;
            end
          end
        end
        READY:   state_r <= READY;
        IDLE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  logic              win_s, win_zero_s, x_hit_s;
  logic [1:0]        win_pat_s, pat_s;
  logic [4:0]        win_attr_s;
  logic [ROW_W-1:0]  idx_s;

  // Priority resolve: scan high to low so the lowest opaque slot is the last to claim the pixel.
  always_comb begin
    win_s      = 1'b0;
    win_zero_s = 1'b0;
    win_pat_s  = 2'b00;
    win_attr_s = 5'b00000;
    x_hit_s    = 1'b0;
    pat_s      = 2'b00;
    idx_s      = {ROW_W{1'b0}};
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      x_hit_s = ({1'b0, slot_x_r[i]} <= bus.pix_x) && (bus.pix_x < ({1'b0, slot_x_r[i]} + TILE_9));
      idx_s   = ~(bus.pix_x[ROW_W-1:0] - slot_x_r[i][ROW_W-1:0]);
      pat_s   = {slot_p1_r[i][idx_s], slot_p0_r[i][idx_s]};
      if ((SLOT_CW'(i) < slot_cnt_r) && x_hit_s && (pat_s != 2'b00)) begin
        win_s      = 1'b1;
        win_pat_s  = pat_s;
        win_attr_s = slot_attr_r[i];
        win_zero_s = slot_zero_r[i];
      end else begin
        win_s = win_s;
      end
    end
  end

  // Registered sprite pixel, forced transparent outside a valid pixel on a ready line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pal_r    <= 5'b00000;
      opaque_r <= 1'b0;
      behind_r <= 1'b0;
      zero_r   <= 1'b0;
    end else if (bus.pix_valid && ready_r && win_s) begin
      pal_r    <= {win_attr_s[2:0], win_pat_s};
      opaque_r <= 1'b1;
      behind_r <= win_attr_s[3];
      zero_r   <= win_zero_s;
    end else begin
      pal_r    <= 5'b00000;
      opaque_r <= 1'b0;
      behind_r <= 1'b0;
      zero_r   <= 1'b0;
    end
  end

  assign bus.oam_addr      = oam_addr_r;
  assign bus.pat_addr      = pat_addr_r;
  assign bus.overflow      = overflow_r;
  assign bus.ready         = ready_r;
  assign bus.spr_pal_index = pal_r;
  assign bus.spr_opaque    = opaque_r;
  assign bus.spr_behind    = behind_r;
  assign bus.spr_zero      = zero_r;
endmodule

// File: tb/tb_ppu_sprite_line_engine.sv
// Self-checking bench for ppu_sprite_line_engine: line scenarios with pixel vector tables
// checked through a one-cycle-latency scoreboard, plus reset and restart sequences.
module tb_ppu_sprite_line_engine;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ppu_sprite_line_engine_if #(.NUM_SPRITES(64), .TILE_SIZE(16), .PAT_ADDR_W(12)) bus ();

  ppu_sprite_line_engine #(
    .NUM_SPRITES(64), .MAX_PER_LINE(8), .TILE_SIZE(16), .PAT_ADDR_W(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] oam_mem  [64];
  logic [15:0] pat0_mem [4096];
  logic [15:0] pat1_mem [4096];

  // Memory models: one cycle from address to data.
  always @(posedge clk) begin
    cyc            <= cyc + 1;
    bus.oam_data   <= oam_mem[bus.oam_addr];
    bus.pat_plane0 <= pat0_mem[bus.pat_addr];
    bus.pat_plane1 <= pat1_mem[bus.pat_addr];
  end

  typedef struct {
    logic [8:0] x;
    logic       valid;
    logic       opq;
    logic [4:0] pal;
    logic       beh;
    logic       zero;
  } pix_vec_t;

  typedef struct {
    pix_vec_t v;
    int       due;
  } sb_t;

  pix_vec_t    vecs [24];
  sb_t         sbq [$];
  logic [11:0] fetch_log [$];

  function automatic pix_vec_t mk(input int x, input logic valid, input logic opq,
                                  input logic [4:0] pal, input logic beh, input logic zero);
    pix_vec_t r;
    r.x = 9'(x); r.valid = valid; r.opq = opq; r.pal = pal; r.beh = beh; r.zero = zero;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any due scoreboard entry.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      checks++;
      if ({bus.spr_opaque, bus.spr_pal_index, bus.spr_behind, bus.spr_zero} !==
          {e.v.opq, e.v.pal, e.v.beh, e.v.zero}) begin
        errors++;
        $display("FAIL pix x=%0d: got opq=%b pal=%b beh=%b zero=%b, expected opq=%b pal=%b beh=%b zero=%b",
                 e.v.x, bus.spr_opaque, bus.spr_pal_index, bus.spr_behind, bus.spr_zero,
                 e.v.opq, e.v.pal, e.v.beh, e.v.zero);
      end
    end
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick();
      bus.pix_x     = vecs[i].x;
      bus.pix_valid = vecs[i].valid;
      sbq.push_back('{v: vecs[i], due: cyc + 1});
    end
    tick();
    bus.pix_valid = 1'b0;
    for (int k = 0; k < 4 && sbq.size() > 0; k++) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pix_drain: got %0d pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic start_line(input logic [7:0] l);
    tick();
    bus.line_start = 1'b1;
    bus.eval_line  = l;
    tick();
    bus.line_start = 1'b0;
  endtask

  task automatic wait_ready(input int max_n, output int n);
    logic [11:0] last;
    n = 0;
    fetch_log.delete();
    last = bus.pat_addr;
    while (bus.ready !== 1'b1 && n < max_n) begin
      tick();
      n++;
      if (bus.pat_addr != last) begin
        fetch_log.push_back(bus.pat_addr);
        last = bus.pat_addr;
      end
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) oam_mem[i] = {8'h00, 8'h00, 8'd240, 8'h00};
  endtask

  function automatic logic [31:0] all_outs();
    return {4'h0, bus.oam_addr, bus.pat_addr, bus.ready, bus.overflow,
            bus.spr_opaque, bus.spr_pal_index, bus.spr_behind, bus.spr_zero};
  endfunction

  initial begin
    int n;
    // Pixel vector tables, one section per scenario.
    vecs[0] = mk(20, 1'b1, 1'b1, 5'b00101, 1'b0, 1'b1);
    vecs[1] = mk(21, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[2] = mk(20, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[3] = mk(19, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[4] = mk(35, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] p;
      p = 3'(i);
      vecs[5 + i] = mk(30 * i, 1'b1, 1'b1, {p, 2'b01}, (i == 2), (i == 0));
    end
    vecs[13] = mk(240, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[14] = mk(0,   1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[15] = mk(5,   1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[16] = mk(250, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[17] = mk(100, 1'b1, 1'b1, 5'b10111, 1'b0, 1'b0);
    vecs[18] = mk(101, 1'b1, 1'b1, 5'b01101, 1'b0, 1'b0);
    vecs[19] = mk(100, 1'b1, 1'b1, 5'b01101, 1'b0, 1'b0);
    vecs[20] = mk(50,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[21] = mk(64,  1'b1, 1'b0, 5'b00000, 1'b0, 1'b0);
    vecs[22] = mk(65,  1'b1, 1'b1, 5'b00001, 1'b0, 1'b1);
    vecs[23] = mk(165, 1'b1, 1'b1, 5'b00010, 1'b0, 1'b0);

    reset = 1'b0;
    bus.line_start = 1'b0; bus.eval_line = 8'd0; bus.pix_valid = 1'b0; bus.pix_x = 9'd0;
    clear_oam();
    for (int i = 0; i < 4096; i++) begin pat0_mem[i] = 16'h0000; pat1_mem[i] = 16'h0000; end
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 32'h0);
    reset = 1'b1;
    tick();

    // Single sprite, entry 0.
    oam_mem[0] = {8'h01, 8'd2, 8'd10, 8'd20};
    pat0_mem[34] = 16'h8000;
    start_line(8'd12);
    wait_ready(200, n);
    chk("t1_ready_cycles", n, 67);
    chk("t1_overflow", bus.overflow, 0);
    apply_vecs(0, 4);

    // Nine sprites on line 0: overflow, entry 8 dropped.
    clear_oam();
    for (int i = 0; i < 9; i++)
      oam_mem[i] = {(i == 2) ? 8'h22 : 8'(i), 8'd1, 8'd0, 8'(30 * i)};
    pat0_mem[16] = 16'h8000;
    start_line(8'd0);
    wait_ready(200, n);
    chk("t2_ready_cycles", n, 81);
    chk("t2_overflow", bus.overflow, 1);
    apply_vecs(5, 13);

    // No wrap: y=250 misses line 5, FETCH skipped.
    for (int i = 0; i < 64; i++) oam_mem[i] = {8'h00, 8'h00, 8'd250, 8'h00};
    start_line(8'd5);
    wait_ready(200, n);
    chk("t3_ready_cycles", n, 65);
    chk("t3_overflow", bus.overflow, 0);
    apply_vecs(14, 16);

    // Overlap priority: transparent pixel of entry 3 does not mask entry 5.
    clear_oam();
    oam_mem[3] = {8'h03, 8'd3, 8'd50, 8'd100};
    oam_mem[5] = {8'h05, 8'd5, 8'd50, 8'd100};
    pat0_mem[48] = 16'h7FFF;
    pat0_mem[80] = 16'hFFFF; pat1_mem[80] = 16'hFFFF;
    start_line(8'd50);
    wait_ready(200, n);
    chk("t4a_ready_cycles", n, 69);
    apply_vecs(17, 18);
    pat0_mem[48] = 16'hFFFF;
    start_line(8'd50);
    wait_ready(200, n);
    chk("t4b_ready_cycles", n, 69);
    apply_vecs(19, 19);

    // Horizontal flip on entry 0, vertical flip on entry 1.
    clear_oam();
    oam_mem[0] = {8'h40, 8'd4, 8'd60, 8'd50};
    oam_mem[1] = {8'h80, 8'd6, 8'd60, 8'd150};
    pat0_mem[64]  = 16'h8000;
    pat1_mem[111] = 16'h0001;
    start_line(8'd60);
    wait_ready(200, n);
    chk("t5_ready_cycles", n, 69);
    chk("t5_fetch_count", fetch_log.size(), 2);
    if (fetch_log.size() == 2) begin
      chk("t5_pat_addr_hflip", fetch_log[0], 64);
      chk("t5_pat_addr_vflip", fetch_log[1], 111);
    end
    apply_vecs(20, 23);

    // line_start reissued mid-FETCH restarts evaluation.
    clear_oam();
    for (int i = 0; i < 9; i++)
      oam_mem[i] = {(i == 2) ? 8'h22 : 8'(i), 8'd1, 8'd0, 8'(30 * i)};
    start_line(8'd0);
    repeat (70) tick();
    chk("t6_midfetch_ready", bus.ready, 0);
    chk("t6_midfetch_overflow", bus.overflow, 1);
    start_line(8'd0);
    chk("t6_restart_overflow", bus.overflow, 0);
    chk("t6_restart_ready", bus.ready, 0);
    chk("t6_restart_oam_addr", bus.oam_addr, 0);
    tick();
    chk("t6_restart_oam_addr1", bus.oam_addr, 1);
    wait_ready(200, n);
    chk("t6_ready_cycles", n, 80);
    chk("t6_overflow", bus.overflow, 1);

    // line_start from READY drops ready; reset mid-EVAL clears everything at once.
    start_line(8'd0);
    chk("t7_ready_drop", bus.ready, 0);
    repeat (10) tick();
    chk("t7_eval_oam_addr", bus.oam_addr, 10);
    #2 reset = 1'b0;
    #1 chk("t7_async_reset_outputs", all_outs(), 32'h0);
    tick();
    reset = 1'b1;
    repeat (100) tick();
    chk("t7_ready_after_reset", bus.ready, 0);
    chk("t7_outputs_after_reset", all_outs(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
